keyring_delay_loader: RTL and testbench
=======================================

Name: keyring_delay_loader

Overview:
On-chip sequencer that programs the KeyRing delay-line scan chain (ExS keyring delays plus the mul/div delays, L bits each) from a parallel configuration vector. It replaces bench-driven shifting of the delay chain. It sits beside top: it drives the chain's delay_en/delay_cfg pins and holds the core in reset until the chain is fully loaded and settled.

Parameters:
DE_FLAT, 234, total scan-chain length in bits ((6*6+3)*L with L=6); vector width and shift count.
SETTLE_CYCLES, 5, cycles with o_delay_en low and core reset still held, after the last shift.
CNT_W, 8, shift/settle counter width; must satisfy 2**CNT_W > max(DE_FLAT, SETTLE_CYCLES).

Ports:
i_clk  in  1  system clock; the scan chain shifts on the same rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_start  in  1  single-cycle load request.
i_cfg  in  DE_FLAT  parallel delay vector; captured on accepted i_start.
i_delay_so  in  1  chain scan-out; used only with DELAY_LOADER_READBACK_EN.
o_delay_en  out  1  scan-chain shift enable.
o_delay_cfg  out  1  scan-chain serial data.
o_core_rstn  out  1  active-low core reset.
o_busy  out  1  high while a load is in progress.
o_done  out  1  one-cycle pulse when the core is released.
o_cfg_err  out  1  sticky readback mismatch flag.

Behaviour:
- Reset values: o_delay_en=0, o_delay_cfg=0, o_core_rstn=0, o_busy=0, o_done=0, o_cfg_err=0, FSM=IDLE, counter=0, vector register=0.
- All outputs are registered. Reset is asserted asynchronously and released synchronously.
- FSM states: IDLE, SHIFT, (VERIFY), SETTLE, RUN.
- IDLE -> SHIFT on i_start=1.
  - i_cfg is latched into the shift register.
  - o_busy=1 and o_core_rstn=0 from the next cycle.
- SHIFT:
  - If i_start is sampled at edge t, then o_delay_en=1 from cycle t+1 through cycle t+DE_FLAT (exactly DE_FLAT cycles).
  - o_delay_cfg=i_cfg[k] in cycle t+1+k, LSB first.
  - The register rotates, so the vector is preserved.
  - After the last bit: go to VERIFY if the macro is defined, otherwise to SETTLE.
- SETTLE: o_delay_en=0 and o_delay_cfg=0 for SETTLE_CYCLES cycles, with the counter reused.
- RUN entry:
  - o_core_rstn rises to 1 and o_done pulses 1 cycle in the same cycle.
  - o_busy falls to 0 in that cycle.
- RUN -> SHIFT on i_start (reconfiguration):
  - o_core_rstn drops to 0 the next cycle, before the first shift bit.
  - o_cfg_err is cleared at that point.
- i_start while o_busy=1 is ignored. No queuing; i_cfg changes during a load have no effect.
- SETTLE_CYCLES=0: the core is released the cycle after the last shift (or the last verify bit).
- i_rst mid-load: immediate return to reset values. Chain contents are undefined; a new i_start is required.
- Counter counts 0..DE_FLAT-1 and never wraps past its terminal value.

Optional Feature:
DELAY_LOADER_READBACK_EN
- Defined:
  - After SHIFT, VERIFY re-shifts the same vector for another DE_FLAT cycles, timed identically to SHIFT.
  - Each received i_delay_so bit is compared with the bit leaving the chain, which equals i_cfg[k] in order.
  - The comparison is taken with o_delay_en high.
  - Any mismatch sets o_cfg_err, which stays set until reset or the next load.
  - The core is still released after SETTLE regardless of o_cfg_err.
  - Chain contents are unchanged by VERIFY.
- Undefined: no VERIFY state, i_delay_so unused, o_cfg_err tied 0.

Decomposition:
- tb_pkg/keyring package holds:
  - KEYRING_DE_FLAT as the DE_FLAT source.
  - t_keyring_delay_flat as the i_cfg type.
  - The enum t_loader_state {IDLE, SHIFT, VERIFY, SETTLE, RUN}.
- One sub-module, delay_shift_ctr: a loadable down-counter with terminal-count flag, shared by SHIFT/VERIFY/SETTLE.
- The FSM and the rotating register stay in keyring_delay_loader.

Test Plan:
- Reset then idle 10 cycles -> o_core_rstn=0, o_delay_en=0, o_busy=0 throughout.
- i_start with i_cfg = alternating 0101... (DE_FLAT=234):
  - o_delay_en high exactly 234 cycles.
  - o_delay_cfg sequence 1,0,1,0,... starting from bit 0.
  - o_core_rstn rises 5 cycles after o_delay_en falls, coincident with a 1-cycle o_done.
  - A shadow shift register in the bench equals i_cfg.
- i_start pulsed again at shift bit 100 -> ignored: shift count stays 234 and the chain holds the first vector.
- Load completes, then i_start in RUN with a new vector:
  - o_core_rstn=0 the next cycle.
  - 234 new bits shifted.
  - Core released again.
- i_rst asserted at shift bit 50 -> all outputs at reset values in the same cycle (asynchronous); new i_start then performs a full 234-bit load.
- With DELAY_LOADER_READBACK_EN, bench chain model inverts the bit at position 17 -> o_cfg_err=1 after VERIFY, o_core_rstn still released; a clean chain model gives o_cfg_err=0.

Source files
------------

// File: rtl/keyring_delay_loader_pkg.sv
// keyring_delay_loader_pkg
//   Shared definitions for the KeyRing delay-chain loader: chain geometry,
//   the parallel configuration vector type and the loader state encoding.
//   No ports (package).
package keyring_delay_loader_pkg;

  // Delay-line width per element and total chain length:
  // 6 ExS units x 6 keyring delays plus 3 mul/div delays, L bits each.
  localparam int KEYRING_L       = 6;
  localparam int KEYRING_DE_FLAT = (6 * 6 + 3) * KEYRING_L;

  typedef logic [KEYRING_DE_FLAT-1:0] t_keyring_delay_flat;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    VERIFY = 3'd2,
    SETTLE = 3'd3,
    RUN    = 3'd4
  } t_loader_state;

endpackage

// File: rtl/keyring_delay_loader_shift_ctr.sv
// delay_shift_ctr
//   Loadable down-counter with terminal-count flag. One instance is shared by
//   the SHIFT, VERIFY and SETTLE phases of the loader. It stops at zero and
//   never wraps.
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset (count -> 0)
//   load      in   load load_val (has priority over dec)
//   load_val  in   CNT_W value to load
//   dec       in   decrement by one when count is non-zero
//   tc        out  high while count == 0
module delay_shift_ctr #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] count_r;

  // Counter register: load wins, otherwise saturating decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != '0)) begin
      count_r <= count_r - CNT_W'(1);
    end
  end

  assign tc = (count_r == '0);

endmodule

// File: rtl/keyring_delay_loader.sv
// keyring_delay_loader
//   Programs the KeyRing delay-line scan chain from a parallel vector and
//   holds the core in reset until the chain is loaded and has settled.
//   The vector is shifted out LSB first through a rotating register, so the
//   register holds the original vector again when the shift completes.
//   Optional feature macro: DELAY_LOADER_READBACK_EN
//     defined   -> a VERIFY pass re-shifts the same vector and compares the
//                  chain scan-out with the bit leaving the chain; any
//                  mismatch sets the sticky o_cfg_err.
//     undefined -> no VERIFY pass, i_delay_so ignored, o_cfg_err stays 0.
// Ports:
//   i_clk        in   clock; the chain shifts on the same rising edge
//   i_rst        in   asynchronous active-high reset
//   i_start      in   single-cycle load request (ignored while busy)
//   i_cfg        in   DE_FLAT-bit delay vector, captured on accepted start
//   i_delay_so   in   chain scan-out (readback build only)
//   o_delay_en   out  chain shift enable
//   o_delay_cfg  out  chain serial data
//   o_core_rstn  out  active-low core reset
//   o_busy       out  load in progress
//   o_done       out  one-cycle pulse when the core is released
//   o_cfg_err    out  sticky readback mismatch flag
module keyring_delay_loader
  import keyring_delay_loader_pkg::*;
#(
  parameter int DE_FLAT       = KEYRING_DE_FLAT,
  parameter int SETTLE_CYCLES = 5,
  parameter int CNT_W         = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [DE_FLAT-1:0] i_cfg,
  input  logic               i_delay_so,
  output logic               o_delay_en,
  output logic               o_delay_cfg,
  output logic               o_core_rstn,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_cfg_err
);

  localparam logic [CNT_W-1:0] SHIFT_LOAD  = CNT_W'(DE_FLAT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

  t_loader_state    state_r;
  logic [DE_FLAT-1:0] vec_r;
  logic             en_r;
  logic             cfg_bit_r;
  logic             core_rstn_r;
  logic             busy_r;
  logic             done_r;
  logic             cfg_err_r;

  logic             ctr_load_s;
  logic [CNT_W-1:0] ctr_load_val_s;
  logic             ctr_dec_s;
  logic             ctr_tc_s;
  logic             so_mismatch_s;

`ifdef DELAY_LOADER_READBACK_EN
  localparam bit READBACK = 1'b1;
  // The re-shifted bit equals the bit leaving the chain, so the outgoing
  // serial bit is the reference for the scan-out.
  assign so_mismatch_s = i_delay_so ^ cfg_bit_r;
`else
  localparam bit READBACK = 1'b0;
  logic so_unused_s;
  assign so_unused_s   = i_delay_so;
  assign so_mismatch_s = 1'b0;
`endif

  // Rotate right by one: the LSB leaves first and re-enters at the top.
  function automatic logic [DE_FLAT-1:0] rotate_out(input logic [DE_FLAT-1:0] v);
    return {v[0], v[DE_FLAT-1:1]};
  endfunction

  delay_shift_ctr #(
    .CNT_W (CNT_W)
  ) u_ctr (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (ctr_load_s),
    .load_val (ctr_load_val_s),
    .dec      (ctr_dec_s),
    .tc       (ctr_tc_s)
  );

  // Counter control: one count per shifted bit or settle cycle; reloaded on
  // each phase change.
  always_comb begin
    ctr_load_s     = 1'b0;
    ctr_load_val_s = SHIFT_LOAD;
    ctr_dec_s      = 1'b0;
    case (state_r)
      IDLE, RUN: begin
        if (i_start) ctr_load_s = 1'b1;
        else         ctr_load_s = 1'b0;
      end
      SHIFT, VERIFY: begin
        if (!ctr_tc_s) begin
          ctr_dec_s = 1'b1;
        end else if ((state_r == SHIFT) && READBACK) begin
          ctr_load_s = 1'b1;
        end else begin
          ctr_load_s     = 1'b1;
          ctr_load_val_s = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (!ctr_tc_s) ctr_dec_s = 1'b1;
        else           ctr_dec_s = 1'b0;
      end
      default: begin
        ctr_load_s = 1'b0;
        ctr_dec_s  = 1'b0;
      end
    endcase
  end

  // Loader FSM with registered chain, reset and status outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= IDLE;
      vec_r       <= '0;
      en_r        <= 1'b0;
      cfg_bit_r   <= 1'b0;
      core_rstn_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, RUN: begin
          if (i_start) begin
            // Bit 0 goes out directly; the register is pre-rotated by one.
            state_r     <= SHIFT;
            vec_r       <= rotate_out(i_cfg);
            en_r        <= 1'b1;
            cfg_bit_r   <= i_cfg[0];
            core_rstn_r <= 1'b0;
            busy_r      <= 1'b1;
            cfg_err_r   <= 1'b0;
          end
        end
        SHIFT, VERIFY: begin
          if (state_r == VERIFY) begin
            cfg_err_r <= cfg_err_r | so_mismatch_s;
          end
          if (!ctr_tc_s || ((state_r == SHIFT) && READBACK)) begin
            // Keep shifting; on the last SHIFT bit of a readback build the
            // register is back to the original vector, so VERIFY just
            // continues the rotation without a gap in o_delay_en.
            cfg_bit_r <= vec_r[0];
            vec_r     <= rotate_out(vec_r);
            if (ctr_tc_s) state_r <= VERIFY;
          end else begin
            en_r      <= 1'b0;
            cfg_bit_r <= 1'b0;
            if (SETTLE_CYCLES == 0) begin
              state_r     <= RUN;
              core_rstn_r <= 1'b1;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              state_r <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (ctr_tc_s) begin
            state_r     <= RUN;
            core_rstn_r <= 1'b1;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign o_delay_en  = en_r;
  assign o_delay_cfg = cfg_bit_r;
  assign o_core_rstn = core_rstn_r;
  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_keyring_delay_loader.sv
// tb_keyring_delay_loader
//   Self-checking bench for keyring_delay_loader with a behavioural scan-chain
//   model and a serial-bit scoreboard. Works with or without
//   DELAY_LOADER_READBACK_EN defined.
module tb_keyring_delay_loader;
  import keyring_delay_loader_pkg::*;

  localparam int N      = KEYRING_DE_FLAT;
  localparam int SETTLE = 5;
`ifdef DELAY_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  localparam int EN_LEN = RB ? 2 * N : N;
  localparam int BUDGET = 2 * N + SETTLE + 40;

  logic clk = 1'b0;
  logic rst;
  logic start;
  t_keyring_delay_flat cfg;
  logic delay_so;
  logic delay_en, delay_cfg, core_rstn, busy, done, cfg_err;

  always #5 clk = ~clk;

  keyring_delay_loader #(
    .DE_FLAT       (N),
    .SETTLE_CYCLES (SETTLE),
    .CNT_W         (8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_cfg       (cfg),
    .i_delay_so  (delay_so),
    .o_delay_en  (delay_en),
    .o_delay_cfg (delay_cfg),
    .o_core_rstn (core_rstn),
    .o_busy      (busy),
    .o_done      (done),
    .o_cfg_err   (cfg_err)
  );

  // Scan-chain model: first bit in is first bit out; after N shifts sr == vector.
  t_keyring_delay_flat sr = '0;
  int unsigned shift_total = 0;
  int unsigned fault_at = 0;
  logic fault_en = 1'b0;

  always @(posedge clk) begin
    if (delay_en === 1'b1) begin
      sr          <= {delay_cfg, sr[N-1:1]};
      shift_total <= shift_total + 1;
    end
  end

  assign delay_so = sr[0] ^ (fault_en && (shift_total == fault_at));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0, en_cnt = 0, first_en_cyc = 0, last_en_cyc = 0;
  int done_cnt = 0, done_cyc = 0;
  logic rstn_at_done, busy_at_done;
  bit exp_q[$];
  bit obs_q[$];

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (delay_en === 1'b1) begin
      if (en_cnt == 0) first_en_cyc = cyc;
      en_cnt++;
      last_en_cyc = cyc;
      obs_q.push_back(delay_cfg);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc     = cyc;
      rstn_at_done = core_rstn;
      busy_at_done = busy;
    end
  endtask

  function automatic t_keyring_delay_flat rand_vec();
    t_keyring_delay_flat v;
    for (int k = 0; k < N; k++) v[k] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Drive a start pulse and push the expected serial stream.
  task automatic begin_load(input t_keyring_delay_flat v);
    en_cnt = 0;
    obs_q.delete();
    exp_q.delete();
    for (int p = 0; p < (RB ? 2 : 1); p++)
      for (int k = 0; k < N; k++) exp_q.push_back(v[k]);
    cfg   = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg   = rand_vec();
  endtask

  task automatic wait_done(output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cfg = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({core_rstn, delay_en, busy, done, delay_cfg, cfg_err} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: rstn/en/busy/done/cfg/err=%b expected 000000", i,
                 {core_rstn, delay_en, busy, done, delay_cfg, cfg_err});
      end
    end
  endtask

  task automatic test_alternating();
    t_keyring_delay_flat v;
    bit ok;
    int nbad;
    for (int k = 0; k < N; k++) v[k] = (k % 2 == 0);
    begin_load(v);
    vectors++;
    if ({delay_en, busy, core_rstn} !== 3'b110) begin
      miscompares++;
      $display("FAIL alt_first_cycle en/busy/rstn=%b expected 110", {delay_en, busy, core_rstn});
    end
    wait_done(ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL alt_done_timeout no o_done within %0d cycles", BUDGET); end
    vectors++;
    if (en_cnt !== EN_LEN || (last_en_cyc - first_en_cyc + 1) !== EN_LEN) begin
      miscompares++;
      $display("FAIL alt_en_len en cycles=%0d span=%0d expected %0d", en_cnt,
               last_en_cyc - first_en_cyc + 1, EN_LEN);
    end
    vectors++;
    if ((done_cyc - last_en_cyc) !== SETTLE + 1) begin
      miscompares++;
      $display("FAIL alt_settle release %0d cycles after last shift expected %0d",
               done_cyc - last_en_cyc, SETTLE + 1);
    end
    vectors++;
    if ({rstn_at_done, busy_at_done} !== 2'b10) begin
      miscompares++;
      $display("FAIL alt_release rstn/busy at done=%b expected 10", {rstn_at_done, busy_at_done});
    end
    tick();
    vectors++;
    if ({done, core_rstn} !== 2'b01) begin
      miscompares++;
      $display("FAIL alt_done_pulse done/rstn=%b expected 01", {done, core_rstn});
    end
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL alt_bit_count got %0d bits expected %0d", obs_q.size(), exp_q.size());
    end
    nbad = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0)
      if (obs_q.pop_front() !== exp_q.pop_front()) nbad++;
    vectors++;
    if (nbad != 0) begin miscompares++; $display("FAIL alt_bits %0d serial bits wrong expected 0", nbad); end
    vectors++;
    if (sr !== v) begin miscompares++; $display("FAIL alt_shadow chain=%h expected %h", sr, v); end
    vectors++;
    if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL alt_cfg_err got %b expected 0", cfg_err); end
  endtask

  task automatic test_ignore_start();
    t_keyring_delay_flat v1;
    bit ok;
    int nbad;
    v1 = rand_vec();
    begin_load(v1);
    for (int i = 0; i < N && en_cnt < 100; i++) tick();
    cfg   = ~v1;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if ({busy, delay_en, core_rstn} !== 3'b110) begin
      miscompares++;
      $display("FAIL ign_busy busy/en/rstn=%b expected 110", {busy, delay_en, core_rstn});
    end
    wait_done(ok);
    vectors++;
    if (!ok || en_cnt !== EN_LEN) begin
      miscompares++;
      $display("FAIL ign_en_len done=%b en cycles=%0d expected 1/%0d", ok, en_cnt, EN_LEN);
    end
    nbad = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0)
      if (obs_q.pop_front() !== exp_q.pop_front()) nbad++;
    vectors++;
    if (nbad != 0 || obs_q.size() != 0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL ign_bits wrong=%0d leftover obs=%0d exp=%0d expected 0/0/0", nbad,
               obs_q.size(), exp_q.size());
    end
    vectors++;
    if (sr !== v1) begin miscompares++; $display("FAIL ign_shadow chain=%h expected %h", sr, v1); end
  endtask

  task automatic test_reconfig();
    t_keyring_delay_flat v;
    bit ok;
    int nbad;
    v = rand_vec();
    vectors++;
    if (core_rstn !== 1'b1) begin miscompares++; $display("FAIL rcfg_run rstn=%b expected 1", core_rstn); end
    begin_load(v);
    vectors++;
    if ({core_rstn, delay_en, busy} !== 3'b011) begin
      miscompares++;
      $display("FAIL rcfg_drop rstn/en/busy=%b expected 011", {core_rstn, delay_en, busy});
    end
    wait_done(ok);
    vectors++;
    if (!ok || en_cnt !== EN_LEN || rstn_at_done !== 1'b1) begin
      miscompares++;
      $display("FAIL rcfg_load done=%b en=%0d rstn=%b expected 1/%0d/1", ok, en_cnt, rstn_at_done, EN_LEN);
    end
    nbad = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0)
      if (obs_q.pop_front() !== exp_q.pop_front()) nbad++;
    vectors++;
    if (nbad != 0) begin miscompares++; $display("FAIL rcfg_bits %0d serial bits wrong expected 0", nbad); end
    vectors++;
    if (sr !== v) begin miscompares++; $display("FAIL rcfg_shadow chain=%h expected %h", sr, v); end
  endtask

  task automatic test_mid_reset();
    t_keyring_delay_flat v;
    bit ok;
    int nbad;
    v = rand_vec();
    begin_load(v);
    for (int i = 0; i < N && en_cnt < 50; i++) tick();
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({delay_en, delay_cfg, core_rstn, busy, done, cfg_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL mrst_async en/cfg/rstn/busy/done/err=%b expected 000000",
               {delay_en, delay_cfg, core_rstn, busy, done, cfg_err});
    end
    tick();
    rst = 1'b0;
    tick(); tick();
    vectors++;
    if ({delay_en, core_rstn, busy} !== 3'b0) begin
      miscompares++;
      $display("FAIL mrst_idle en/rstn/busy=%b expected 000", {delay_en, core_rstn, busy});
    end
    v = rand_vec();
    begin_load(v);
    wait_done(ok);
    vectors++;
    if (!ok || en_cnt !== EN_LEN) begin
      miscompares++;
      $display("FAIL mrst_reload done=%b en=%0d expected 1/%0d", ok, en_cnt, EN_LEN);
    end
    nbad = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0)
      if (obs_q.pop_front() !== exp_q.pop_front()) nbad++;
    vectors++;
    if (nbad != 0 || sr !== v) begin
      miscompares++;
      $display("FAIL mrst_bits wrong=%0d chain=%h expected 0/%h", nbad, sr, v);
    end
  endtask

  task automatic test_readback();
    t_keyring_delay_flat v;
    bit ok;
    v = rand_vec();
    fault_at = shift_total + N + 17;
    fault_en = 1'b1;
    begin_load(v);
    wait_done(ok);
    fault_en = 1'b0;
    tick();
    vectors++;
    if (!ok || cfg_err !== RB || core_rstn !== 1'b1) begin
      miscompares++;
      $display("FAIL rb_fault done=%b err=%b rstn=%b expected 1/%b/1", ok, cfg_err, core_rstn, RB);
    end
    v = rand_vec();
    begin_load(v);
    vectors++;
    if (cfg_err !== 1'b0) begin miscompares++; $display("FAIL rb_clear err=%b expected 0", cfg_err); end
    wait_done(ok);
    tick();
    vectors++;
    if (!ok || cfg_err !== 1'b0 || core_rstn !== 1'b1 || sr !== v) begin
      miscompares++;
      $display("FAIL rb_clean done=%b err=%b rstn=%b chain_ok=%b expected 1/0/1/1", ok, cfg_err,
               core_rstn, sr === v);
    end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_ignore_start();
    test_reconfig();
    test_mid_reset();
    test_readback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
